// File: rtl/k051962_plane.sv
// k051962_plane: pixel-side receiver for one tile layer.
// Latches a tile (GFX word, colour, flip) on each LOAD and serialises its
// eight PIXW-bit pixels at the CE6 rate, shifted by a fine horizontal scroll
// that straddles the previous (B) and newest (A) tile.
// Optional build macro: K051962_TRANSP_EN adds the OPQ opacity output and
// zeroes PCOL for transparent pixels.
module k051962_plane #(
  parameter int PIXW = 4,
  parameter int COLW = 8
) (
  input  logic              M24,
  input  logic              RES,
  input  logic              CE6,
  input  logic              LOAD,
  input  logic [8*PIXW-1:0] GD,
  input  logic [COLW-1:0]   COL,
  input  logic              FLIPX,
  input  logic [2:0]        ZH,
  input  logic              BLANKn,
  output logic [PIXW-1:0]   PIX,
  output logic [COLW-1:0]   PCOL
`ifdef K051962_TRANSP_EN
  ,
  output logic              OPQ
`endif
);

  typedef struct packed {
    logic [8*PIXW-1:0] gd;
    logic [COLW-1:0]   col;
    logic              flip;
  } tile_t;

  tile_t             a_q, a_d, b_q, b_d;
  logic [2:0]        zh_q, zh_d, ph_q, ph_d;
  logic [PIXW-1:0]   pix_q, pix_d;
  logic [COLW-1:0]   pcol_q, pcol_d;
`ifdef K051962_TRANSP_EN
  logic              opq_q, opq_d;
`endif

  logic [3:0]        idx;
  tile_t             src;
  logic [2:0]        col_n, col_c;
  logic [PIXW-1:0]   pix_sel;

  // Window select: scroll offset walks from the tail of B into the head of A.
  always_comb begin
    idx   = {1'b0, ph_q} + {1'b0, zh_q};
    src   = idx[3] ? a_q : b_q;
    col_n = idx[2:0];
    col_c = src.flip ? ~col_n : col_n;
  end

  // One bit per bitplane; bit 7 of each plane byte is the leftmost column.
  for (genvar p = 0; p < PIXW; p++) begin : g_pl
    logic [7:0] pl;
    assign pl         = src.gd[8*p +: 8];
    assign pix_sel[p] = pl[~col_c];
  end

  // Tile/phase next state: LOAD shifts A into B and restarts the column count.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    zh_d = zh_q;
    ph_d = ph_q;
    if (CE6) begin
      if (LOAD) begin
        b_d  = a_q;
        a_d  = '{gd: GD, col: COL, flip: FLIPX};
        zh_d = ZH;
        ph_d = 3'd0;
      end else begin
        ph_d = ph_q + 3'd1;
      end
    end
  end

  // Output next state: blanking only masks the pixel, never the shifter.
  always_comb begin
    pix_d  = pix_q;
    pcol_d = pcol_q;
`ifdef K051962_TRANSP_EN
    opq_d  = opq_q;
    if (CE6) begin
      pix_d  = BLANKn ? pix_sel : '0;
      opq_d  = BLANKn && (|pix_sel);
      pcol_d = (BLANKn && (|pix_sel)) ? src.col : '0;
    end
`else
    if (CE6) begin
      pix_d  = BLANKn ? pix_sel : '0;
      pcol_d = src.col;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge M24) begin
    if (!RES) begin
      a_q    <= '0;
      b_q    <= '0;
      zh_q   <= '0;
      ph_q   <= '0;
      pix_q  <= '0;
      pcol_q <= '0;
`ifdef K051962_TRANSP_EN
      opq_q  <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      zh_q   <= zh_d;
      ph_q   <= ph_d;
      pix_q  <= pix_d;
      pcol_q <= pcol_d;
`ifdef K051962_TRANSP_EN
      opq_q  <= opq_d;
`endif
    end
  end

  assign PIX  = pix_q;
  assign PCOL = pcol_q;
`ifdef K051962_TRANSP_EN
  assign OPQ  = opq_q;
`endif

endmodule

// File: tb/tb_k051962_plane.sv
// Directed bench for k051962_plane: one task per scenario, inline checks.
module tb_k051962_plane;

  logic        M24 = 1'b0;
  logic        RES = 1'b0;
  logic        CE6 = 1'b0;
  logic        LOAD = 1'b0;
  logic [31:0] GD = '0;
  logic [7:0]  COL = '0;
  logic        FLIPX = 1'b0;
  logic [2:0]  ZH = '0;
  logic        BLANKn = 1'b1;
  logic [3:0]  PIX;
  logic [7:0]  PCOL;
`ifdef K051962_TRANSP_EN
  logic        OPQ;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  k051962_plane #(.PIXW(4), .COLW(8)) dut (
    .M24(M24), .RES(RES), .CE6(CE6), .LOAD(LOAD), .GD(GD), .COL(COL),
    .FLIPX(FLIPX), .ZH(ZH), .BLANKn(BLANKn), .PIX(PIX), .PCOL(PCOL)
`ifdef K051962_TRANSP_EN
    , .OPQ(OPQ)
`endif
  );

  always #5 M24 = ~M24;

  // Expected PCOL for a given expected pixel and tile colour.
  function automatic logic [7:0] epc(input logic [3:0] p, input logic [7:0] c);
`ifdef K051962_TRANSP_EN
    return (p != 4'd0) ? c : 8'h00;
`else
    return c;
`endif
  endfunction

  // One pixel period: CE6 high for one M24 edge out of four; returns at a negedge.
  task automatic step(input logic ld);
    @(negedge M24); LOAD = ld; CE6 = 1'b1;
    @(negedge M24); CE6 = 1'b0; LOAD = 1'b0;
    repeat (2) @(negedge M24);
  endtask

  task automatic load(input logic [31:0] g, input logic [7:0] c, input logic fx, input logic [2:0] z);
    GD = g; COL = c; FLIPX = fx; ZH = z;
    step(1'b1);
  endtask

  task automatic do_reset;
    RES = 1'b0; BLANKn = 1'b1;
    step(1'b0); step(1'b0);
    RES = 1'b1;
  endtask

  task automatic test_reset;
    RES = 1'b0; GD = 32'hFFFF_FFFF; COL = 8'hFF; ZH = 3'd5;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_cmp++;
      if ({PIX, PCOL} !== {4'h0, 8'h00}) begin
        n_bad++;
        $display("FAIL reset[%0d]: PIX=%h PCOL=%h want 0/00", i, PIX, PCOL);
      end
    end
    RES = 1'b1; GD = '0; COL = '0; ZH = '0;
    step(1'b0);
    n_cmp++;
    if ({PIX, PCOL} !== {4'h0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_release: PIX=%h PCOL=%h want 0/00", PIX, PCOL);
    end
  endtask

  task automatic test_basic;
    logic [3:0] ep;
    do_reset;
    load(32'h0000_00F0, 8'h12, 1'b0, 3'd0);
    repeat (7) step(1'b0);
    load(32'hFF00_0000, 8'h34, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) load(32'h0, 8'h56, 1'b0, 3'd0); else step(1'b0);
      ep = (i < 4) ? 4'd1 : 4'd0;
      n_cmp++;
      if ({PIX, PCOL} !== {ep, epc(ep, 8'h12)}) begin
        n_bad++;
        $display("FAIL basic_t1[%0d]: PIX=%h PCOL=%h want %h/%h", i, PIX, PCOL, ep, epc(ep, 8'h12));
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      n_cmp++;
      if ({PIX, PCOL} !== {4'h8, 8'h34}) begin
        n_bad++;
        $display("FAIL basic_t2[%0d]: PIX=%h PCOL=%h want 8/34", i, PIX, PCOL);
      end
    end
  endtask

  task automatic test_scroll;
    logic [3:0] ep;
    logic [7:0] ec;
    do_reset;
    load(32'h0000_00F0, 8'h12, 1'b0, 3'd3);
    repeat (7) step(1'b0);
    load(32'hFF00_0000, 8'h34, 1'b0, 3'd3);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      if (i < 5) begin ep = (i == 0) ? 4'd1 : 4'd0; ec = 8'h12; end
      else       begin ep = 4'd8; ec = 8'h34; end
      n_cmp++;
      if ({PIX, PCOL} !== {ep, epc(ep, ec)}) begin
        n_bad++;
        $display("FAIL scroll[%0d]: PIX=%h PCOL=%h want %h/%h", i, PIX, PCOL, ep, epc(ep, ec));
      end
    end
  endtask

  task automatic test_flip;
    logic [3:0] ep;
    do_reset;
    load(32'h0000_0001, 8'h12, 1'b1, 3'd0);
    repeat (7) step(1'b0);
    load(32'h0, 8'h34, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      ep = (i == 0) ? 4'd1 : 4'd0;
      n_cmp++;
      if ({PIX, PCOL} !== {ep, epc(ep, 8'h12)}) begin
        n_bad++;
        $display("FAIL flip[%0d]: PIX=%h PCOL=%h want %h/%h", i, PIX, PCOL, ep, epc(ep, 8'h12));
      end
    end
  endtask

  task automatic test_load_ce0;
    logic [3:0] ep;
    do_reset;
    load(32'h0000_00F0, 8'h12, 1'b0, 3'd0);
    repeat (7) step(1'b0);
    load(32'hFF00_0000, 8'h34, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        // LOAD with CE6 low must be ignored entirely.
        GD = 32'h0F0F_0F0F; COL = 8'h99; FLIPX = 1'b1; ZH = 3'd6; LOAD = 1'b1;
        repeat (4) @(negedge M24);
        LOAD = 1'b0;
      end
      if (i == 7) load(32'h0, 8'h56, 1'b0, 3'd0); else step(1'b0);
      ep = (i < 4) ? 4'd1 : 4'd0;
      n_cmp++;
      if ({PIX, PCOL} !== {ep, epc(ep, 8'h12)}) begin
        n_bad++;
        $display("FAIL ce0_load[%0d]: PIX=%h PCOL=%h want %h/%h", i, PIX, PCOL, ep, epc(ep, 8'h12));
      end
    end
    step(1'b0);
    n_cmp++;
    if ({PIX, PCOL} !== {4'h8, 8'h34}) begin
      n_bad++;
      $display("FAIL ce0_tileA: PIX=%h PCOL=%h want 8/34", PIX, PCOL);
    end
  endtask

  task automatic test_early_load;
    logic [3:0] ep;
    logic [7:0] ec;
    do_reset;
    load(32'h0000_00F0, 8'h12, 1'b0, 3'd0);
    repeat (7) step(1'b0);
    load(32'hFF00_0000, 8'h34, 1'b0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) load(32'h0, 8'h56, 1'b0, 3'd2); else step(1'b0);
      ep = (i < 2) ? 4'd1 : 4'd0;
      n_cmp++;
      if ({PIX, PCOL} !== {ep, epc(ep, 8'h12)}) begin
        n_bad++;
        $display("FAIL early_pre[%0d]: PIX=%h PCOL=%h want %h/%h", i, PIX, PCOL, ep, epc(ep, 8'h12));
      end
    end
    for (int j = 0; j < 7; j++) begin
      step(1'b0);
      if (j < 6) begin ep = 4'd8; ec = 8'h34; end
      else       begin ep = 4'd0; ec = 8'h56; end
      n_cmp++;
      if ({PIX, PCOL} !== {ep, epc(ep, ec)}) begin
        n_bad++;
        $display("FAIL early_post[%0d]: PIX=%h PCOL=%h want %h/%h", j, PIX, PCOL, ep, epc(ep, ec));
      end
    end
  endtask

  task automatic test_blank;
    logic [3:0] ep;
    do_reset;
    load(32'h0000_00F0, 8'h12, 1'b0, 3'd0);
    repeat (7) step(1'b0);
    load(32'hFF00_0000, 8'h34, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      BLANKn = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      step(1'b0);
      ep = (BLANKn && i < 4) ? 4'd1 : 4'd0;
      n_cmp++;
      if ({PIX, PCOL} !== {ep, epc(ep, 8'h12)}) begin
        n_bad++;
        $display("FAIL blank[%0d]: PIX=%h PCOL=%h want %h/%h", i, PIX, PCOL, ep, epc(ep, 8'h12));
      end
    end
    BLANKn = 1'b1;
  endtask

`ifdef K051962_TRANSP_EN
  task automatic test_transp;
    do_reset;
    load(32'h0080_0080, 8'h7A, 1'b0, 3'd0);
    repeat (7) step(1'b0);
    load(32'h0, 8'h34, 1'b0, 3'd0);
    step(1'b0);
    n_cmp++;
    if ({OPQ, PIX, PCOL} !== {1'b1, 4'h5, 8'h7A}) begin
      n_bad++;
      $display("FAIL transp_opaque: OPQ=%b PIX=%h PCOL=%h want 1/5/7a", OPQ, PIX, PCOL);
    end
    step(1'b0);
    n_cmp++;
    if ({OPQ, PIX, PCOL} !== {1'b0, 4'h0, 8'h00}) begin
      n_bad++;
      $display("FAIL transp_clear: OPQ=%b PIX=%h PCOL=%h want 0/0/00", OPQ, PIX, PCOL);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_scroll;
    test_flip;
    test_load_ce0;
    test_early_load;
    test_blank;
`ifdef K051962_TRANSP_EN
    test_transp;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
